crop_capture_ctrl: RTL and testbench
====================================

Name: crop_capture_ctrl

Overview:
- Controls the crop stage of the camera pixel path and sequences single-frame snapshots.
- Holds a software-written crop window in staged registers. Commits it to active registers only at frame start, so the window never changes mid-frame.
- Drives a registered per-pixel crop enable and runs an arm/capture/done state machine that frames exactly one cropped frame per request.
- Sits between the CCD capture counters (H/V count, FVAL/LVAL) and the crop/RGB stage, alongside the SDRAM writer.

Parameters:
- CW, 13, width of H/V counters and window registers.
- DEF_H_START, 256, reset value of horizontal window start (inclusive).
- DEF_H_END, 640, reset value of horizontal window end (exclusive).
- DEF_V_START, 0, reset value of vertical window start (inclusive).
- DEF_V_END, 480, reset value of vertical window end (exclusive).
- PCW, 24, captured-pixel counter width.

Ports:
- iCLK  in  1  pixel clock
- iRST  in  1  asynchronous reset, active-low
- iFVAL  in  1  frame valid from capture
- iLVAL  in  1  line valid from capture
- iH_Cont  in  CW  current pixel column
- iV_Cont  in  CW  current pixel row
- iCfg_WE  in  1  config write strobe
- iCfg_Addr  in  2  0=H_START 1=H_END 2=V_START 3=V_END
- iCfg_Data  in  CW  config write data
- iCapture  in  1  snapshot request, single-cycle pulse
- iAbort  in  1  abort an armed or running capture
- oCrop_En  out  1  current pixel lies inside the active window
- oCap_En  out  1  oCrop_En qualified by CAPTURE state
- oBusy  out  1  state is ARMED or CAPTURE
- oDone  out  1  one-cycle pulse when a capture completes
- oCfg_Err  out  1  sticky: last commit was rejected
- oPix_Cnt  out  PCW  pixels captured in the current or last snapshot
- oH_Start, oH_End, oV_Start, oV_End  out  CW each  active window

Behaviour:
- Reset (async, iRST low):
  - staged and active windows load the DEF_* values;
  - state=IDLE; all 1-bit outputs 0; oPix_Cnt=0; fval_d=0.
- Config write: iCfg_WE updates the addressed staged register on the next edge. Writes are accepted in any state.
- Frame start (fs) = iFVAL & ~fval_d, where fval_d is iFVAL registered. If iFVAL is already high when reset releases, no fs is generated until the next rising edge.
- Frame end (fe) = ~iFVAL & fval_d.
- Commit: on fs, when state is not CAPTURE and the state does not enter CAPTURE on this fs:
  - staged→active if H_START<H_END and V_START<V_END (unsigned compare);
  - otherwise active is unchanged and oCfg_Err is set.
  - oCfg_Err clears on the next successful commit.
- ARMED→CAPTURE on fs also commits first: the snapshot uses the newly committed window.
- Window freeze: the active window never changes while state=CAPTURE.
- oCrop_En is registered, 1-cycle latency. It is high when iFVAL & iLVAL & H_START<=iH_Cont<H_END & V_START<=iV_Cont<V_END (half-open intervals).
- oCap_En = oCrop_En AND (state==CAPTURE), evaluated in the same cycle.
- FSM:
  - IDLE: iCapture → ARMED; oPix_Cnt cleared to 0 on this transition.
  - ARMED: fs → CAPTURE; iAbort → IDLE.
  - CAPTURE: oPix_Cnt increments by 1 each cycle oCap_En is high, saturating at all-ones. fe → DONE; iAbort → IDLE with no oDone.
  - DONE: oDone=1 for exactly this cycle, then unconditionally → IDLE.
- Precedence and boundary cases:
  - iAbort and iCapture in the same cycle: abort wins.
  - iCapture while ARMED, CAPTURE or DONE is ignored.
  - iAbort in IDLE or DONE is ignored.
  - fs and fe in the same cycle cannot occur, since both are derived from one FVAL edge.
  - A frame already in progress when ARMED is entered is skipped; capture starts at the next fs.
  - Reset mid-capture returns to IDLE with defaults; no oDone.
- Config write and commit in the same cycle: the commit uses the pre-write staged value; the write lands after it.

Decomposition:
- Shared package: FSM state encoding (IDLE, ARMED, CAPTURE, DONE; 2 bits), config address constants, and the default window constants, so the crop and SDRAM blocks share them.
- One natural sub-module: crop_window_regs, holding the staged/active registers, validity check and commit logic. The FSM, edge detection and crop compare stay in the top level.

Test Plan:
- Default window after reset, no capture, one frame with H sweep 0..1279 at V=10 -> oCrop_En high for exactly H=256..639 (384 cycles, 1-cycle delayed); oCap_En stays 0.
- Write H_START=100, H_END=200 mid-frame -> current frame still crops 256..639; next frame crops 100..199; oH_Start=100 from the fs edge.
- Write H_START=300, H_END=300, then fs -> oCfg_Err=1, active stays 256/640. Then write H_END=400, next fs -> oCfg_Err=0, window 300..399.
- iCapture mid-frame on a 640x480 frame -> waits for the next fs; oBusy=1 throughout; oPix_Cnt=384*480=184320; oDone pulses once, one cycle after FVAL falls.
- iAbort during CAPTURE at row 100 -> IDLE next cycle, no oDone, oPix_Cnt holds its partial count. iCapture and iAbort in the same cycle from IDLE -> stays IDLE.
- iRST asserted mid-CAPTURE -> all outputs 0, window back to defaults. iFVAL high at release -> no capture or commit until the next FVAL rising edge.

Source files
------------

// File: rtl/crop_capture_ctrl_pkg.sv
// Shared definitions for the crop / snapshot path: FSM encoding, config
// register addresses and the default crop window.
package crop_capture_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } capState_t;

    localparam logic [1:0] CFG_H_START = 2'd0;
    localparam logic [1:0] CFG_H_END   = 2'd1;
    localparam logic [1:0] CFG_V_START = 2'd2;
    localparam logic [1:0] CFG_V_END   = 2'd3;

    localparam int unsigned PKG_DEF_H_START = 32'd256;
    localparam int unsigned PKG_DEF_H_END   = 32'd640;
    localparam int unsigned PKG_DEF_V_START = 32'd0;
    localparam int unsigned PKG_DEF_V_END   = 32'd480;

    // A window is usable only when both half-open intervals are non-empty.
    function automatic logic windowOk(input logic [31:0] hStart,
                                      input logic [31:0] hEnd,
                                      input logic [31:0] vStart,
                                      input logic [31:0] vEnd);
        return (hStart < hEnd) && (vStart < vEnd);
    endfunction

endpackage

// File: rtl/crop_window_regs.sv
// Staged and active crop window registers. Software writes land in the
// staged copy at any time; the active copy only changes on a commit, which
// the top level issues at frame start outside of a capture.
module crop_window_regs
    import crop_capture_ctrl_pkg::*;
#(
    parameter int unsigned CW          = 13,
    parameter int unsigned DEF_H_START = PKG_DEF_H_START,
    parameter int unsigned DEF_H_END   = PKG_DEF_H_END,
    parameter int unsigned DEF_V_START = PKG_DEF_V_START,
    parameter int unsigned DEF_V_END   = PKG_DEF_V_END
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iCfg_WE,
    input  logic [1:0]    iCfg_Addr,
    input  logic [CW-1:0] iCfg_Data,
    input  logic          iCommit,
    output logic [CW-1:0] oH_Start,
    output logic [CW-1:0] oH_End,
    output logic [CW-1:0] oV_Start,
    output logic [CW-1:0] oV_End,
    output logic          oCfg_Err
);

    logic [CW-1:0] stagedHStart;
    logic [CW-1:0] stagedHEnd;
    logic [CW-1:0] stagedVStart;
    logic [CW-1:0] stagedVEnd;
    logic          stagedOk;

    assign stagedOk = windowOk(32'(stagedHStart), 32'(stagedHEnd),
                               32'(stagedVStart), 32'(stagedVEnd));

    // Software-visible staged window; a write in the commit cycle lands after
    // the commit has already sampled the old staged value.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            stagedHStart <= CW'(DEF_H_START);
            stagedHEnd   <= CW'(DEF_H_END);
            stagedVStart <= CW'(DEF_V_START);
            stagedVEnd   <= CW'(DEF_V_END);
        end else if (iCfg_WE) begin
            case (iCfg_Addr)
                CFG_H_START: stagedHStart <= iCfg_Data;
                CFG_H_END:   stagedHEnd   <= iCfg_Data;
                CFG_V_START: stagedVStart <= iCfg_Data;
                CFG_V_END:   stagedVEnd   <= iCfg_Data;
                default:     stagedHStart <= stagedHStart;
            endcase
        end
    end

    // Active window and sticky error: a bad staged window is refused at commit.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oH_Start <= CW'(DEF_H_START);
            oH_End   <= CW'(DEF_H_END);
            oV_Start <= CW'(DEF_V_START);
            oV_End   <= CW'(DEF_V_END);
            oCfg_Err <= 1'b0;
        end else if (iCommit && stagedOk) begin
            oH_Start <= stagedHStart;
            oH_End   <= stagedHEnd;
            oV_Start <= stagedVStart;
            oV_End   <= stagedVEnd;
            oCfg_Err <= 1'b0;
        end else if (iCommit) begin
            oCfg_Err <= 1'b1;
        end
    end

endmodule

// File: rtl/crop_capture_ctrl.sv
// Crop stage controller: frame-edge detection, per-pixel crop enable and the
// single-frame snapshot sequencer (IDLE -> ARMED -> CAPTURE -> DONE).
module crop_capture_ctrl
    import crop_capture_ctrl_pkg::*;
#(
    parameter int unsigned CW          = 13,
    parameter int unsigned DEF_H_START = PKG_DEF_H_START,
    parameter int unsigned DEF_H_END   = PKG_DEF_H_END,
    parameter int unsigned DEF_V_START = PKG_DEF_V_START,
    parameter int unsigned DEF_V_END   = PKG_DEF_V_END,
    parameter int unsigned PCW         = 24
) (
    input  logic           iCLK,
    input  logic           iRST,
    input  logic           iFVAL,
    input  logic           iLVAL,
    input  logic [CW-1:0]  iH_Cont,
    input  logic [CW-1:0]  iV_Cont,
    input  logic           iCfg_WE,
    input  logic [1:0]     iCfg_Addr,
    input  logic [CW-1:0]  iCfg_Data,
    input  logic           iCapture,
    input  logic           iAbort,
    output logic           oCrop_En,
    output logic           oCap_En,
    output logic           oBusy,
    output logic           oDone,
    output logic           oCfg_Err,
    output logic [PCW-1:0] oPix_Cnt,
    output logic [CW-1:0]  oH_Start,
    output logic [CW-1:0]  oH_End,
    output logic [CW-1:0]  oV_Start,
    output logic [CW-1:0]  oV_End
);

    capState_t state;
    capState_t nextState;
    logic      fvalD;
    logic      fvalPrimed;
    logic      frameStart;
    logic      frameEnd;
    logic      commit;
    logic      clearCnt;
    logic      insideWin;

    // A frame start needs FVAL to have been seen low since reset, so a frame
    // already running at reset release is not treated as a new one.
    assign frameStart = iFVAL & ~fvalD & fvalPrimed;
    assign frameEnd   = ~iFVAL & fvalD;

    // The window is frozen during a capture; ARMED->CAPTURE commits first.
    assign commit = frameStart & (state != ST_CAPTURE);

    assign insideWin = iFVAL & iLVAL
                     & (iH_Cont >= oH_Start) & (iH_Cont < oH_End)
                     & (iV_Cont >= oV_Start) & (iV_Cont < oV_End);

    crop_window_regs #(
        .CW          (CW),
        .DEF_H_START (DEF_H_START),
        .DEF_H_END   (DEF_H_END),
        .DEF_V_START (DEF_V_START),
        .DEF_V_END   (DEF_V_END)
    ) uWinRegs (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iCfg_WE   (iCfg_WE),
        .iCfg_Addr (iCfg_Addr),
        .iCfg_Data (iCfg_Data),
        .iCommit   (commit),
        .oH_Start  (oH_Start),
        .oH_End    (oH_End),
        .oV_Start  (oV_Start),
        .oV_End    (oV_End),
        .oCfg_Err  (oCfg_Err)
    );

    // FVAL history for edge detection.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fvalD      <= 1'b0;
            fvalPrimed <= 1'b0;
        end else begin
            fvalD      <= iFVAL;
            fvalPrimed <= fvalPrimed | ~iFVAL;
        end
    end

    // Registered crop enable, one pixel clock behind the counters.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oCrop_En <= 1'b0;
        end else begin
            oCrop_En <= insideWin;
        end
    end

    // Snapshot FSM state register.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Snapshot FSM next state; abort takes priority over every other event.
    always_comb begin
        nextState = state;
        clearCnt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iCapture && !iAbort) begin
                    nextState = ST_ARMED;
                    clearCnt  = 1'b1;
                end else begin
                    nextState = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (iAbort) begin
                    nextState = ST_IDLE;
                end else if (frameStart) begin
                    nextState = ST_CAPTURE;
                end else begin
                    nextState = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                if (iAbort) begin
                    nextState = ST_IDLE;
                end else if (frameEnd) begin
                    nextState = ST_DONE;
                end else begin
                    nextState = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                nextState = ST_IDLE;
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    assign oCap_En = oCrop_En & (state == ST_CAPTURE);
    assign oBusy   = (state == ST_ARMED) | (state == ST_CAPTURE);
    assign oDone   = (state == ST_DONE);

    // Captured-pixel counter: cleared on arming, saturates at all-ones.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oPix_Cnt <= {PCW{1'b0}};
        end else if (clearCnt) begin
            oPix_Cnt <= {PCW{1'b0}};
        end else if (oCap_En && (oPix_Cnt != {PCW{1'b1}})) begin
            oPix_Cnt <= oPix_Cnt + PCW'(1);
        end
    end

endmodule

// File: tb/tb_crop_capture_ctrl.sv
// Bench for crop_capture_ctrl: directed frames, per-cycle comparison against
// a behavioural model, plus hand-computed totals.
module tb_crop_capture_ctrl;

    localparam int CW     = 13;
    localparam int PCW    = 12;
    localparam int PIXMAX = (1 << PCW) - 1;

    logic           iCLK = 1'b0;
    logic           iRST = 1'b0;
    logic           iFVAL = 1'b0;
    logic           iLVAL = 1'b0;
    logic [CW-1:0]  iH_Cont = '0;
    logic [CW-1:0]  iV_Cont = '0;
    logic           iCfg_WE = 1'b0;
    logic [1:0]     iCfg_Addr = 2'd0;
    logic [CW-1:0]  iCfg_Data = '0;
    logic           iCapture = 1'b0;
    logic           iAbort = 1'b0;
    logic           oCrop_En, oCap_En, oBusy, oDone, oCfg_Err;
    logic [PCW-1:0] oPix_Cnt;
    logic [CW-1:0]  oH_Start, oH_End, oV_Start, oV_End;

    crop_capture_ctrl #(.CW(CW), .PCW(PCW)) dut (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iLVAL(iLVAL),
        .iH_Cont(iH_Cont), .iV_Cont(iV_Cont), .iCfg_WE(iCfg_WE),
        .iCfg_Addr(iCfg_Addr), .iCfg_Data(iCfg_Data), .iCapture(iCapture),
        .iAbort(iAbort), .oCrop_En(oCrop_En), .oCap_En(oCap_En),
        .oBusy(oBusy), .oDone(oDone), .oCfg_Err(oCfg_Err),
        .oPix_Cnt(oPix_Cnt), .oH_Start(oH_Start), .oH_End(oH_End),
        .oV_Start(oV_Start), .oV_End(oV_End)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: window as array {hStart, hEnd, vStart, vEnd}; snapshot as a mode.
    localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_DONE = 3;
    int  mStaged[4];
    int  mActive[4];
    int  mMode;
    int  mCnt;
    bit  mCrop, mErr, mPrevFval, mSeenLow;
    int  cropCycles = 0;
    int  capCycles  = 0;
    int  doneCount  = 0;

    function automatic bit inWindow(input int w[4], input int h, input int v);
        return (h >= w[0]) && (h < w[1]) && (v >= w[2]) && (v < w[3]);
    endfunction

    // Model step on each edge, then compare DUT outputs just after the edge.
    always @(posedge iCLK) begin
        if (!iRST) begin
            mStaged   = '{256, 640, 0, 480};
            mActive   = '{256, 640, 0, 480};
            mMode     = M_IDLE;
            mCnt      = 0;
            mCrop     = 1'b0;
            mErr      = 1'b0;
            mPrevFval = 1'b0;
            mSeenLow  = 1'b0;
        end else begin
            bit newFrame, endFrame, counting;
            newFrame = iFVAL && !mPrevFval && mSeenLow;
            endFrame = !iFVAL && mPrevFval;
            counting = mCrop && (mMode == M_CAP);
            mCrop = iFVAL && iLVAL && inWindow(mActive, int'(iH_Cont), int'(iV_Cont));
            if (newFrame && mMode != M_CAP) begin
                if (mStaged[0] < mStaged[1] && mStaged[2] < mStaged[3]) begin
                    mActive = mStaged;
                    mErr = 1'b0;
                end else begin
                    mErr = 1'b1;
                end
            end
            if (mMode == M_CAP && counting && mCnt < PIXMAX) mCnt++;
            case (mMode)
                M_IDLE:  if (iCapture && !iAbort) begin mMode = M_ARMED; mCnt = 0; end
                M_ARMED: if (iAbort) mMode = M_IDLE; else if (newFrame) mMode = M_CAP;
                M_CAP:   if (iAbort) mMode = M_IDLE; else if (endFrame) mMode = M_DONE;
                default: mMode = M_IDLE;
            endcase
            if (iCfg_WE) mStaged[iCfg_Addr] = int'(iCfg_Data);
            mPrevFval = iFVAL;
            if (!iFVAL) mSeenLow = 1'b1;
        end
        #1;
        check("crop_en", int'(oCrop_En), int'(mCrop));
        check("cap_en",  int'(oCap_En),  int'(mCrop && mMode == M_CAP));
        check("busy",    int'(oBusy),    int'(mMode == M_ARMED || mMode == M_CAP));
        check("done",    int'(oDone),    int'(mMode == M_DONE));
        check("cfg_err", int'(oCfg_Err), int'(mErr));
        check("pix_cnt", int'(oPix_Cnt), mCnt);
        check("h_start", int'(oH_Start), mActive[0]);
        check("h_end",   int'(oH_End),   mActive[1]);
        check("v_start", int'(oV_Start), mActive[2]);
        check("v_end",   int'(oV_End),   mActive[3]);
        if (oCrop_En) cropCycles++;
        if (oCap_En)  capCycles++;
        if (oDone)    doneCount++;
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic cfgWrite(input logic [1:0] addr, input int data);
        iCfg_WE = 1'b1; iCfg_Addr = addr; iCfg_Data = CW'(data);
        cyc();
        iCfg_WE = 1'b0;
    endtask

    task automatic frameBegin();
        iFVAL = 1'b1; iLVAL = 1'b0;
        cyc(2);
    endtask

    task automatic frameFinish();
        iFVAL = 1'b0; iLVAL = 1'b0;
        cyc(4);
    endtask

    task automatic row(input int v, input int hFrom, input int hTo);
        iV_Cont = CW'(v);
        iLVAL = 1'b1;
        for (int h = hFrom; h < hTo; h++) begin
            iH_Cont = CW'(h);
            cyc();
        end
        iLVAL = 1'b0;
        cyc(3);
    endtask

    task automatic pulse(input bit cap, input bit abt);
        iCapture = cap; iAbort = abt;
        cyc();
        iCapture = 1'b0; iAbort = 1'b0;
    endtask

    initial begin
        cyc(3);
        iRST = 1'b1;
        cyc(2);
        check("rst_h_start_lit", int'(oH_Start), 256);
        check("rst_h_end_lit",   int'(oH_End),   640);
        check("rst_v_end_lit",   int'(oV_End),   480);
        check("rst_pix_lit",     int'(oPix_Cnt), 0);

        // Default window, full H sweep on row 10.
        cropCycles = 0; capCycles = 0;
        frameBegin(); row(10, 0, 1280); frameFinish();
        check("default_crop_lit", cropCycles, 384);
        check("no_cap_lit", capCycles, 0);

        // Mid-frame write only takes effect at next frame start.
        frameBegin(); row(0, 240, 660);
        cfgWrite(2'd0, 100); cfgWrite(2'd1, 200);
        cropCycles = 0; row(1, 0, 700);
        check("old_window_lit", cropCycles, 384);
        frameFinish();
        frameBegin();
        check("new_hstart_lit", int'(oH_Start), 100);
        cropCycles = 0; row(2, 0, 700);
        check("new_window_lit", cropCycles, 100);
        frameFinish();

        // Empty window is refused, then a good one clears the error.
        cfgWrite(2'd0, 300); cfgWrite(2'd1, 300);
        frameBegin();
        check("err_set_lit", int'(oCfg_Err), 1);
        check("err_keep_lit", int'(oH_Start), 100);
        frameFinish();
        cfgWrite(2'd1, 400);
        frameBegin();
        check("err_clr_lit", int'(oCfg_Err), 0);
        check("h300_lit", int'(oH_Start), 300);
        check("h400_lit", int'(oH_End), 400);
        frameFinish();
        cfgWrite(2'd0, 256); cfgWrite(2'd1, 640);
        frameBegin(); frameFinish();

        // Capture requested mid-frame waits for the next frame.
        doneCount = 0;
        frameBegin(); row(0, 240, 660);
        pulse(1'b1, 1'b0);
        check("armed_busy_lit", int'(oBusy), 1);
        row(1, 240, 660); frameFinish();
        check("armed_cnt_lit", int'(oPix_Cnt), 0);
        frameBegin();
        for (int r = 0; r < 4; r++) row(r, 240, 660);
        frameFinish();
        check("cap_cnt_lit", int'(oPix_Cnt), 1536);
        check("cap_done_lit", doneCount, 1);
        check("cap_idle_lit", int'(oBusy), 0);

        // Abort mid-capture keeps the partial count and gives no done.
        doneCount = 0;
        pulse(1'b1, 1'b0);
        frameBegin();
        for (int r = 0; r < 3; r++) row(r, 240, 660);
        pulse(1'b0, 1'b1);
        check("abort_idle_lit", int'(oBusy), 0);
        row(3, 240, 660); frameFinish();
        check("abort_cnt_lit", int'(oPix_Cnt), 1152);
        check("abort_nodone_lit", doneCount, 0);
        pulse(1'b1, 1'b1);
        check("cap_abort_same_lit", int'(oBusy), 0);
        pulse(1'b0, 1'b1);

        // Counter saturation.
        pulse(1'b1, 1'b0);
        frameBegin();
        for (int r = 0; r < 11; r++) row(r, 240, 660);
        frameFinish();
        check("sat_cnt_lit", int'(oPix_Cnt), PIXMAX);

        // Reset mid-capture, released with FVAL still high.
        cfgWrite(2'd0, 300); cfgWrite(2'd1, 400);
        pulse(1'b1, 1'b0);
        frameBegin(); row(0, 240, 660);
        iRST = 1'b0;
        cyc(2);
        check("rst_busy_lit", int'(oBusy), 0);
        check("rst_win_lit", int'(oH_Start), 256);
        check("rst_cnt_lit", int'(oPix_Cnt), 0);
        iRST = 1'b1;
        cyc();
        cfgWrite(2'd0, 300); cfgWrite(2'd1, 400);
        pulse(1'b1, 1'b0);
        capCycles = 0; doneCount = 0;
        row(1, 240, 660);
        check("rel_no_commit_lit", int'(oH_Start), 256);
        check("rel_no_cap_lit", capCycles, 0);
        check("rel_armed_lit", int'(oBusy), 1);
        frameFinish();
        frameBegin();
        for (int r = 0; r < 2; r++) row(r, 240, 660);
        frameFinish();
        check("rel_cap_cnt_lit", int'(oPix_Cnt), 200);
        check("rel_done_lit", doneCount, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
